// File: rtl/pwm_bank.sv
// pwm_bank: bank of CHANNELS edge-aligned PWM outputs that share one period
// counter. Period, duty and polarity are written into shadow registers and
// moved into the active set at each counter wrap, so a running period is never
// disturbed by a write.
//
// Optional feature: define PWM_BANK_POLARITY_EN to add a per-channel output
// polarity mask at write address CHANNELS+1. Without it that address is
// ignored and all channels use normal polarity.
module pwm_bank #(
    parameter int  CHANNELS = 4,
    parameter int  CNT_W    = 16,
    localparam int ADDR_W   = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    output logic [CHANNELS-1:0] wave,
    output logic                period_end
);

    localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(CHANNELS);

    // Shadow (software-visible) and active (in-use) configuration.
    logic [CNT_W-1:0]    sh_period;
    logic [CNT_W-1:0]    sh_duty [CHANNELS];
    logic [CNT_W-1:0]    act_period;
    logic [CNT_W-1:0]    act_duty [CHANNELS];
    logic [CHANNELS-1:0] pol;

    // Shared period counter and control decode.
    logic [CNT_W-1:0]    tim;
    logic                run;
    logic                wrap;
    logic                load;
    logic [CHANNELS-1:0] wave_d;

    // One channel's output level: high while the counter is below the duty,
    // then inverted when the channel's polarity bit is set.
    function automatic logic pwm_level(input logic [CNT_W-1:0] t,
                                       input logic [CNT_W-1:0] d,
                                       input logic             p);
        return (t < d) ^ p;
    endfunction

    // The counter only runs with en high and a non-zero active period.
    assign run  = en && (act_period != '0);
    assign wrap = run && (tim == act_period - CNT_W'(1));
    // Idle or stopped: keep tracking shadow so a new period or duty is
    // picked up immediately; running: only swap at the wrap edge.
    assign load = !run || wrap;

    // Shadow register writes for period and per-channel duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_period <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_duty[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_addr == ADDR_PERIOD) begin
                sh_period <= wr_data;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    sh_duty[i] <= wr_data;
                end
            end
        end
    end

    // Active set takes the pre-edge shadow value, so a write landing on the
    // wrap edge waits for the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_period <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                act_duty[i] <= '0;
            end
        end else if (load) begin
            act_period <= sh_period;
            for (int i = 0; i < CHANNELS; i++) begin
                act_duty[i] <= sh_duty[i];
            end
        end
    end

`ifdef PWM_BANK_POLARITY_EN
    localparam logic [ADDR_W-1:0] ADDR_POL = ADDR_W'(CHANNELS + 1);

    logic [CHANNELS-1:0] sh_pol;
    logic [CHANNELS-1:0] act_pol;

    // Shadow polarity mask write; the mask comes from the low data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_pol <= '0;
        end else if (wr_en && (wr_addr == ADDR_POL)) begin
            sh_pol <= CHANNELS'(wr_data);
        end
    end

    // Active polarity follows the same swap timing as duty and period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_pol <= '0;
        end else if (load) begin
            act_pol <= sh_pol;
        end
    end

    assign pol = act_pol;
`else
    assign pol = '0;
`endif

    // ---- stage boundary: counter -> compare ----
    // Period counter: held at 0 while stopped, wraps to 0 at P-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tim <= '0;
        end else if (!run || wrap) begin
            tim <= '0;
        end else begin
            tim <= tim + CNT_W'(1);
        end
    end

    // Per-channel compare against the pre-edge counter; stopped forces low
    // with polarity not applied.
    always_comb begin
        wave_d = '0;
        if (run) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wave_d[i] = pwm_level(tim, act_duty[i], pol[i]);
            end
        end
    end

    // ---- stage boundary: compare -> outputs ----
    // Registered outputs: PWM levels and the one-cycle wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave       <= '0;
            period_end <= 1'b0;
        end else begin
            wave       <= wave_d;
            period_end <= wrap;
        end
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent PWM outputs sharing one period counter (1..16).
REQ-002 Parameter CNT_W, default 16, width of period counter, period and duty values (4..32).
REQ-003 Local constant ADDR_W = ceil(log2(CHANNELS+2)), width of the write address.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  run enable; low holds counter and forces outputs low.
REQ-007 wr_en  input  1  single-cycle write strobe into shadow registers.
REQ-008 wr_addr  input  ADDR_W  0..CHANNELS-1 selects a channel duty; CHANNELS selects period; CHANNELS+1 selects polarity (see Configuration).
REQ-009 wr_data  input  CNT_W  write value; polarity write uses bits [CHANNELS-1:0].
REQ-010 wave  output  CHANNELS  registered PWM outputs, bit i = channel i.
REQ-011 period_end  output  1  registered one-cycle pulse per counter wrap.

Function
REQ-012 Shadow registers (period, duty per channel) capture wr_data on any clock edge with wr_en high; addresses above CHANNELS+1 are ignored.
REQ-013 Active registers load from shadow at every wrap edge and on every edge while en is low; the load uses the shadow value from before that edge, so a write coinciding with a wrap takes effect at the following wrap.
REQ-014 Counter tim counts 0..P-1 with en high, P = active period; at tim == P-1 the next value is 0 (wrap).
REQ-015 Active period P = 0 holds tim at 0, generates no wrap and no period_end, and forces all wave bits low; active registers keep loading from shadow every cycle while P = 0 so a new period is picked up.
REQ-016 wave[i] is registered: next value = (tim < D[i]) XOR pol[i], sampled with the pre-edge tim and active duty D[i]; one-cycle latency from tim to wave.
REQ-017 D[i] = 0 gives constant low; D[i] >= P gives constant high (before polarity); compare is unsigned CNT_W-bit.
REQ-018 period_end goes high on the edge where tim wraps, for exactly one cycle; P = 1 gives period_end high every cycle.
REQ-019 en low: tim forced to 0, wave forced to 0 (polarity not applied), period_end 0; en rising starts counting from tim = 0 with freshly loaded active values.
REQ-020 Channels are phase-aligned: all rising edges occur on the same cycle (edge-aligned mode only).

Reset
REQ-021 rst high asynchronously clears tim, all shadow and active registers, polarity, wave and period_end to 0.
REQ-022 rst asserted mid-period aborts the period; after release operation restarts from tim = 0 with period 0 (outputs low) until programmed.

Configuration
REQ-023 Macro PWM_BANK_POLARITY_EN defined: address CHANNELS+1 writes shadow polarity mask, loaded into active pol with the same timing as duty (REQ-013).
REQ-024 Macro undefined: no polarity register exists, address CHANNELS+1 is ignored, pol[i] is constant 0.

Verification
REQ-025 Reset, write period 10, duty0 3, duty1 10, en=1 -> wave[0] high 3 cycles / low 7, wave[1] constant high, period_end every 10 cycles.
REQ-026 Duty0 changed 3 -> 7 mid-period -> current period keeps 3-cycle high; next period after the wrap shows 7-cycle high; no glitch.
REQ-027 Write asserted on the wrap edge (tim = P-1) -> new value applied one full period later.
REQ-028 Period 0, then period 1, duty0 1 -> all wave low with no period_end; then wave[0] constant high and period_end high every cycle.
REQ-029 en toggled low for 5 cycles mid-period then high -> wave low within 1 cycle, tim restarts at 0, first high phase full length.
REQ-030 With PWM_BANK_POLARITY_EN, pol mask 0b0001, duty0 3, period 10 -> wave[0] low 3 / high 7 from next wrap; without macro same write -> no change.
